// File: rtl/timer_ctrl.sv
// timer_ctrl: run-control FSM for the egg timer. Watches the BCD countdown
// digits, generates the count tick from the system clock, and drives the
// counter's load / run-gate / tick inputs plus a timed, blinking alarm.
module timer_ctrl #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic [3:0] seconds,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_minutes,
  output logic       load,
  output logic       main_enable,
  output logic       count_enable,
  output logic       alarm,
  output logic       alarm_blink,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SECONDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    ALARM = 3'd5
  } state_t;

  state_t        st;
  logic [PW-1:0] presc;
  logic [7:0]    alarm_cnt;
  logic          load_r;
  logic          zero;
  logic          tick;

  assign zero = (seconds == 4'd0) && (tens_seconds == 4'd0) &&
                (minutes == 4'd0) && (tens_minutes == 4'd0);
  assign tick = (presc == PRESC_MAX);

  // Next state, prescaler, alarm tick counter and the registered load pulse.
  // load_r is set on the edge that enters LOAD, or that returns to IDLE from
  // RUN/PAUSE/ALARM so the display snaps back to the programmed time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      load_r    <= 1'b0;
    end else begin
      load_r <= 1'b0;
      case (st)
        IDLE: begin
          // clear beats start_stop even here, where clear alone does nothing
          if (start_stop && !clear) begin
            st     <= LOAD;
            load_r <= 1'b1;
          end
        end
        LOAD: begin
          st <= clear ? IDLE : ARM;
        end
        ARM: begin
          if (clear || zero) begin
            st <= IDLE;
          end else begin
            st    <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          if (clear) begin
            st     <= IDLE;
            load_r <= 1'b1;
          end else if (zero) begin
            st        <= ALARM;
            presc     <= '0;
            alarm_cnt <= '0;
          end else begin
            // the prescaler still advances on the pausing edge; PAUSE then
            // freezes it so the sub-second fraction survives the pause
            presc <= tick ? '0 : presc + PW'(1);
            if (start_stop) st <= PAUSE;
          end
        end
        PAUSE: begin
          if (clear) begin
            st     <= IDLE;
            load_r <= 1'b1;
          end else if (start_stop) begin
            st <= RUN;
          end
        end
        ALARM: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) alarm_cnt <= alarm_cnt + 8'd1;
          if (clear || start_stop || (tick && (alarm_cnt == ALARM_LAST))) begin
            st     <= IDLE;
            load_r <= 1'b1;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; only main_enable sees the digits.
  always_comb begin
    state        = st;
    load         = load_r;
    main_enable  = (st == RUN) && !zero;
    count_enable = (st == RUN) && tick;
    alarm        = (st == ALARM);
    alarm_blink  = (st == ALARM) && (presc < PRESC_HALF);
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scenario bench for timer_ctrl with a behavioural BCD
// countdown counter closing the loop on the digit inputs.
module tb_timer_ctrl;
  localparam int TD = 4;
  localparam int AS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [15:0] prog = 16'h0000;
  logic        load, main_enable, count_enable, alarm, alarm_blink;
  logic [2:0]  state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_tick_q[$];
  int exp_load_q[$];
  int te, le;

  timer_ctrl #(.TICK_DIV(TD), .ALARM_SECONDS(AS)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .seconds(digits[3:0]), .tens_seconds(digits[7:4]),
    .minutes(digits[11:8]), .tens_minutes(digits[15:12]),
    .load(load), .main_enable(main_enable), .count_enable(count_enable),
    .alarm(alarm), .alarm_blink(alarm_blink), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] s, ts, m, tm;
    {tm, m, ts, s} = d;
    if (s != 4'd0) s = s - 4'd1;
    else begin
      s = 4'd9;
      if (ts != 4'd0) ts = ts - 4'd1;
      else begin
        ts = 4'd5;
        if (m != 4'd0) m = m - 4'd1;
        else begin
          m = 4'd9;
          tm = tm - 4'd1;
        end
      end
    end
    return {tm, m, ts, s};
  endfunction

  // downstream countdown counter model
  always @(posedge clk) begin
    if (load) digits <= prog;
    else if (main_enable && count_enable) digits <= bcd_dec(digits);
  end

  // scoreboard: every tick / load pulse must match the next expected cycle
  always @(negedge clk) begin
    if (count_enable === 1'b1) begin
      checks++;
      if (exp_tick_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected at cyc=%0d required no tick", cyc);
      end else begin
        te = exp_tick_q.pop_front();
        if (cyc !== te) begin
          errors++;
          $display("FAIL tick_cycle actual=%0d required=%0d", cyc, te);
        end
      end
    end
    if (load === 1'b1) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected at cyc=%0d required no load", cyc);
      end else begin
        le = exp_load_q.pop_front();
        if (cyc !== le) begin
          errors++;
          $display("FAIL load_cycle actual=%0d required=%0d", cyc, le);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic check_queues(input string tag);
    checks++;
    if (exp_tick_q.size() != 0 || exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending actual=%0d/%0d required=0/0", tag,
               exp_tick_q.size(), exp_load_q.size());
      exp_tick_q.delete();
      exp_load_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state actual=%0d required=0", state);
    end
    checks++;
    if ({load, main_enable, count_enable, alarm, alarm_blink} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b required=00000",
               {load, main_enable, count_enable, alarm, alarm_blink});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_countdown_alarm();
    int c0;
    logic eb;
    prog = 16'h0003;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    exp_tick_q.push_back(c0 + 6);
    exp_tick_q.push_back(c0 + 10);
    exp_tick_q.push_back(c0 + 14);
    exp_load_q.push_back(c0 + 28);
    pulse_ss();
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL cd_load_state actual=%0d required=1", state);
    end
    goto(c0 + 2);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL cd_arm_state actual=%0d required=2", state);
    end
    goto(c0 + 3);
    checks++;
    if ({state, main_enable} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL cd_run actual=%0d/%b required=3/1", state, main_enable);
    end
    goto(c0 + 14);
    checks++;
    if (digits !== 16'h0001) begin
      errors++; $display("FAIL cd_digits_1 actual=%h required=0001", digits);
    end
    goto(c0 + 15);
    checks++;
    if ({digits, state, main_enable} !== {16'h0000, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL cd_zero_cycle actual=%h/%0d/%b required=0000/3/0",
               digits, state, main_enable);
    end
    for (int k = 0; k < TD * AS; k++) begin
      goto(c0 + 16 + k);
      eb = ((k % TD) < (TD / 2));
      checks++;
      if ({state, alarm} !== {3'd5, 1'b1}) begin
        errors++; $display("FAIL cd_alarm k=%0d actual=%0d/%b required=5/1", k, state, alarm);
      end
      checks++;
      if (alarm_blink !== eb) begin
        errors++; $display("FAIL cd_blink k=%0d actual=%b required=%b", k, alarm_blink, eb);
      end
    end
    goto(c0 + 28);
    checks++;
    if ({state, alarm} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL cd_alarm_end actual=%0d/%b required=0/0", state, alarm);
    end
    goto(c0 + 30);
    check_queues("cd");
  endtask

  task automatic test_pause_resume();
    int c0, p;
    prog = 16'h0100;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    exp_tick_q.push_back(c0 + 6);
    pulse_ss();
    goto(c0 + 8);
    checks++;
    if (digits !== 16'h0059) begin
      errors++; $display("FAIL pr_digits_59 actual=%h required=0059", digits);
    end
    pulse_ss();
    for (int k = 0; k < 20; k++) begin
      goto(c0 + 9 + k);
      checks++;
      if ({state, main_enable} !== {3'd4, 1'b0}) begin
        errors++; $display("FAIL pr_paused k=%0d actual=%0d/%b required=4/0", k, state, main_enable);
      end
    end
    p = c0 + 29;
    goto(p);
    exp_tick_q.push_back(p + 2);
    pulse_ss();
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL pr_resume_state actual=%0d required=3", state);
    end
    goto(p + 3);
    checks++;
    if (digits !== 16'h0058) begin
      errors++; $display("FAIL pr_digits_58 actual=%h required=0058", digits);
    end
    goto(p + 4);
    exp_load_q.push_back(p + 5);
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL pr_clear_wins actual=%0d required=0", state);
    end
    goto(p + 7);
    checks++;
    if ({state, digits} !== {3'd0, 16'h0100}) begin
      errors++; $display("FAIL pr_reloaded actual=%0d/%h required=0/0100", state, digits);
    end
    check_queues("pr");
  endtask

  task automatic test_clear_pause();
    int c0;
    prog = 16'h0005;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    exp_tick_q.push_back(c0 + 6);
    pulse_ss();
    goto(c0 + 8);
    pulse_ss();
    goto(c0 + 12);
    checks++;
    if (state !== 3'd4) begin
      errors++; $display("FAIL cp_paused actual=%0d required=4", state);
    end
    exp_load_q.push_back(c0 + 13);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL cp_idle actual=%0d required=0", state);
    end
    goto(c0 + 15);
    checks++;
    if (digits !== 16'h0005) begin
      errors++; $display("FAIL cp_reloaded actual=%h required=0005", digits);
    end
    check_queues("cp");
  endtask

  task automatic test_alarm_ack();
    int c0;
    prog = 16'h0001;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    exp_tick_q.push_back(c0 + 6);
    pulse_ss();
    goto(c0 + 10);
    checks++;
    if (alarm !== 1'b1) begin
      errors++; $display("FAIL ack_alarm actual=%b required=1", alarm);
    end
    exp_load_q.push_back(c0 + 11);
    pulse_ss();
    checks++;
    if ({state, alarm, alarm_blink} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ack_idle actual=%0d/%b/%b required=0/0/0", state, alarm, alarm_blink);
    end
    goto(c0 + 13);
    check_queues("ack");
  endtask

  task automatic test_zero_load();
    int c0;
    logic [2:0] exp_st[7];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    prog = 16'h0000;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    pulse_ss();
    for (int k = 1; k < 7; k++) begin
      goto(c0 + k);
      checks++;
      if ({state, main_enable, alarm} !== {exp_st[k], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL zl_seq k=%0d actual=%0d/%b/%b required=%0d/0/0",
                 k, state, main_enable, alarm, exp_st[k]);
      end
    end
    check_queues("zl");
  endtask

  task automatic test_async_reset();
    int c0, c1;
    prog = 16'h0009;
    c0 = cyc;
    exp_load_q.push_back(c0 + 1);
    exp_tick_q.push_back(c0 + 6);
    pulse_ss();
    goto(c0 + 8);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL ar_running actual=%0d required=3", state);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({state, load, main_enable, count_enable, alarm, alarm_blink} !== 8'b0) begin
      errors++;
      $display("FAIL ar_async actual=%b required=00000000",
               {state, load, main_enable, count_enable, alarm, alarm_blink});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    c1 = cyc;
    exp_load_q.push_back(c1 + 1);
    exp_tick_q.push_back(c1 + 6);
    pulse_ss();
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL ar_restart_load actual=%0d required=1", state);
    end
    goto(c1 + 3);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL ar_restart_run actual=%0d required=3", state);
    end
    goto(c1 + 7);
    checks++;
    if (digits !== 16'h0008) begin
      errors++; $display("FAIL ar_digits actual=%h required=0008", digits);
    end
    goto(c1 + 8);
    exp_load_q.push_back(c1 + 9);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    goto(c1 + 11);
    check_queues("ar");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown_alarm();
    test_pause_resume();
    test_clear_pause();
    test_alarm_ack();
    test_zero_load();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
